// File: rtl/dff_n_pipe_elastic.sv
// Multi-lane, DEPTH-stage elastic register pipeline with per-stage valid/ready.
// An empty stage always accepts from upstream, so bubbles collapse while the output is stalled.
module dff_n_pipe_elastic #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 3,
  parameter int DEPTH      = 3,
  parameter int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]                occupancy
);

  localparam int W = NUM_LANES * DATA_WIDTH;

  logic [DEPTH-1:0]         r_v;
  logic [DEPTH-1:0][W-1:0]  r_d;
  logic [OCC_W-1:0]         r_occ;

  logic [DEPTH-1:0]         w_rdy;
  logic [DEPTH-1:0]         w_up_v;
  logic [DEPTH-1:0][W-1:0]  w_up_d;
  logic [DEPTH-1:0]         w_v_nxt;
  logic [OCC_W-1:0]         w_occ_nxt;

  // Ready chain folded through a running accumulator: rdy[k] = ~v[k] | rdy[k+1], rdy[DEPTH] = out_ready.
  always_comb begin : ready_chain
    logic w_acc;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_rdy = '0;
    w_acc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_acc    = ~r_v[k] | w_acc;
      w_rdy[k] = w_acc;
    end
  end

  always_comb begin
    w_up_v    = '0;
    w_up_d    = '0;
    w_up_v[0] = in_valid;
    w_up_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_up_v[k] = r_v[k-1];
      w_up_d[k] = r_d[k-1];
    end
  end

  // Flush wins over every stage move; stalled stages keep their valid bit.
  always_comb begin
    w_v_nxt = r_v;
    if (flush) begin
      w_v_nxt = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) w_v_nxt[k] = w_up_v[k];
      end
    end
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[k]);
    end
  end

  // Data registers are reset too, so out_data reads zero during and after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_v   <= '0;
      r_d   <= '0;
      r_occ <= '0;
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
      for (int k = 0; k < DEPTH; k++) begin
        // Data only moves with a real upstream beat, which avoids toggling on bubbles.
        if (!flush && w_rdy[k] && w_up_v[k]) r_d[k] <= w_up_d[k];
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_n_pipe_elastic.sv
// Directed bench for dff_n_pipe_elastic at DEPTH=3, NUM_LANES=3, DATA_WIDTH=8.
// Inputs change 1ns after each rising edge; outputs are sampled 2ns after the edge.
module tb_dff_n_pipe_elastic;

  localparam int DW = 8;
  localparam int NL = 3;
  localparam int DP = 3;
  localparam int OW = $clog2(DP + 1);
  localparam int W  = DW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [OW-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  dff_n_pipe_elastic #(.DATA_WIDTH(DW), .NUM_LANES(NL), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge and land 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; idle_inputs();
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 24'h0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h occ=%0d want v=0 d=000000 occ=0", out_valid, out_data, occupancy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    step(); step();
    rst = 1'b0;
    step();
    // Put two beats in flight with the output stalled, then reset mid-cycle.
    in_valid = 1'b1; in_data = 24'hAAAAAA; step();
    in_data = 24'hBBBBBB; step();
    idle_inputs(); step();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_occ: got %0d want 2", occupancy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 24'h0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h occ=%0d want v=0 d=000000 occ=0", out_valid, out_data, occupancy);
    end
    step();
    #2 rst = 1'b0;
    step();
    // Single beat, latency DEPTH cycles.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 24'h030201;
    step();
    idle_inputs();
    for (int n = 1; n <= 4; n++) begin
      #1;
      checks++;
      if (n < 3 && out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early edge %0d: got v=%b want 0", n, out_valid);
      end else if (n == 3 && (out_valid !== 1'b1 || out_data !== 24'h030201)) begin
        errors++;
        $display("FAIL latency_out: got v=%b d=%h want v=1 d=030201", out_valid, out_data);
      end else if (n == 4 && (out_valid !== 1'b0 || occupancy !== 2'd0)) begin
        errors++;
        $display("FAIL latency_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
      end
      if (n < 4) step();
    end
  endtask

  task automatic test_throughput();
    int exp_occ;
    int pushes;
    int pops;
    out_ready = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      in_valid = (n <= 16);
      in_data  = (n <= 16) ? W'(n) : '0;
      #1;
      if (n <= 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL tput_in_ready beat %0d: got %b want 1", n, in_ready);
        end
      end
      @(posedge clk); #1;
      pushes  = (n < 16) ? n : 16;
      pops    = ((n < 19) ? n : 19) - 3;
      if (pops < 0) pops = 0;
      exp_occ = pushes - pops;
      checks++;
      if (occupancy !== OW'(exp_occ)) begin
        errors++;
        $display("FAIL tput_occ edge %0d: got %0d want %0d", n, occupancy, exp_occ);
      end
      if (n >= 3 && n <= 18) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== W'(n - 2)) begin
          errors++;
          $display("FAIL tput_out edge %0d: got v=%b d=%h want v=1 d=%h", n, out_valid, out_data, W'(n - 2));
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tput_empty: got v=%b want 0", out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_stall_fill();
    logic [W-1:0] beats [5];
    int idx;
    int oidx;
    logic acc;
    beats = '{24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D, 24'h0E0E0E};
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = beats[idx];
      #1;
      checks++;
      if (in_ready !== (c < 3)) begin
        errors++;
        $display("FAIL stall_in_ready cycle %0d: got %b want %b", c, in_ready, (c < 3));
      end
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    checks++;
    if (idx != 3 || occupancy !== 2'd3 || out_data !== beats[0]) begin
      errors++;
      $display("FAIL stall_full: got accepted=%0d occ=%0d d=%h want 3 3 %h", idx, occupancy, out_data, beats[0]);
    end
    out_ready = 1'b1;
    oidx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 5);
      in_data  = (idx < 5) ? beats[idx] : '0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== beats[oidx]) begin
        errors++;
        $display("FAIL stall_drain %0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, beats[oidx]);
      end
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      oidx++;
    end
    idle_inputs();
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || idx != 5) begin
      errors++;
      $display("FAIL stall_end: got v=%b occ=%0d accepted=%0d want 0 0 5", out_valid, occupancy, idx);
    end
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 24'h111111; step();
    idle_inputs(); step(); step();
    in_valid = 1'b1; in_data = 24'h222222; step();
    idle_inputs(); step(); step();
    #1;
    checks++;
    if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 24'h111111 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bubble_state: got occ=%0d v=%b d=%h rdy=%b want 2 1 111111 1", occupancy, out_valid, out_data, in_ready);
    end
    in_valid = 1'b1; in_data = 24'h333333; step();
    idle_inputs();
    #1;
    checks++;
    if (occupancy !== 2'd3 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bubble_full: got occ=%0d rdy=%b want 3 0", occupancy, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(24'h111111 * (c + 1))) begin
        errors++;
        $display("FAIL bubble_order %0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, W'(24'h111111 * (c + 1)));
      end
      step(); #1;
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bubble_empty: got v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 24'hF1F1F1; step();
    in_data = 24'hF2F2F2; step();
    in_data = 24'hF3F3F3; step();
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 24'hF4F4F4;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 24'hF1F1F1) begin
      errors++;
      $display("FAIL flush_cycle: got rdy=%b v=%b d=%h want 0 1 f1f1f1", in_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 24'hF1F1F1) begin
      errors++;
      $display("FAIL flush_after: got occ=%0d v=%b d=%h want 0 0 f1f1f1", occupancy, out_valid, out_data);
    end
    step(); step(); step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_no_capture: got v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      in_valid = 1'b1; in_data = W'(24'h505050 + j); step();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_data = W'(24'h505054 + j);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== W'(24'h505051 + j)) begin
        errors++;
        $display("FAIL b2b_cycle %0d: got rdy=%b v=%b d=%h want 1 1 %h", j, in_ready, out_valid, out_data, W'(24'h505051 + j));
      end
      @(posedge clk); #1;
      checks++;
      if (occupancy !== 2'd3) begin
        errors++;
        $display("FAIL b2b_occ %0d: got %0d want 3", j, occupancy);
      end
    end
    idle_inputs();
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(24'h505055 + j)) begin
        errors++;
        $display("FAIL b2b_drain %0d: got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, W'(24'h505055 + j));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL b2b_empty: got v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_stall_fill();
    test_bubble_collapse();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
